// File: rtl/mole_game_ctrl.sv
// rtl/mole_game_ctrl.sv - whack-a-mole game controller: input sync, FSM, LFSR mole placement, scoring.
// Optional MOLE_MISS_PENALTY_EN: each miss decrements the score, saturating at 0.
module mole_game_ctrl #(
    parameter int MOLE_PERIOD = 100000000,
    parameter int SCORE_MAX   = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] btn,
    input  logic [4:0] time_left,
    output logic       timer_rst,
    output logic [3:0] mole,
    output logic [6:0] score,
    output logic       game_over
);

    localparam int CW = $clog2(MOLE_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(MOLE_PERIOD - 1);
    localparam logic [6:0]    SMAX = 7'(SCORE_MAX);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t        state_q, state_n;
    logic          start_s1, start_s2, start_d;
    logic [3:0]    btn_s1, btn_s2, btn_d;
    logic [7:0]    lfsr_q;
    logic [6:0]    score_q, score_n;
    logic [3:0]    mole_q, mole_n;
    logic [1:0]    idx_q, idx_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          seen_q, seen_n;
    logic          restart_q, restart_n;

    logic          start_edge;
    logic [3:0]    btn_edge;
    logic [1:0]    cand_idx, new_idx;
    logic [3:0]    new_mole;
    logic          hit;

    assign start_edge = start_s2 & ~start_d;
    assign btn_edge   = btn_s2 & ~btn_d;

    // A relocated mole must always move, so a repeat of the current index is bumped by one.
    assign cand_idx = lfsr_q[1:0];
    assign new_idx  = (cand_idx == idx_q) ? cand_idx + 2'd1 : cand_idx;
    assign new_mole = 4'b0001 << new_idx;
    assign hit      = (btn_edge == mole_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_s1  <= 1'b0;
            start_s2  <= 1'b0;
            start_d   <= 1'b0;
            btn_s1    <= 4'b0;
            btn_s2    <= 4'b0;
            btn_d     <= 4'b0;
            lfsr_q    <= 8'hA5;
            state_q   <= IDLE;
            score_q   <= 7'd0;
            mole_q    <= 4'b0;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            seen_q    <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            start_s1  <= start;
            start_s2  <= start_s1;
            start_d   <= start_s2;
            btn_s1    <= btn;
            btn_s2    <= btn_s1;
            btn_d     <= btn_s2;
            lfsr_q    <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            state_q   <= state_n;
            score_q   <= score_n;
            mole_q    <= mole_n;
            idx_q     <= idx_n;
            cnt_q     <= cnt_n;
            seen_q    <= seen_n;
            restart_q <= restart_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        score_n   = score_q;
        mole_n    = mole_q;
        idx_n     = idx_q;
        cnt_n     = cnt_q;
        seen_n    = seen_q;
        restart_n = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (start_edge) begin
                    state_n = PLAY;
                    score_n = 7'd0;
                    seen_n  = 1'b0;
                    cnt_n   = '0;
                    mole_n  = new_mole;
                    idx_n   = new_idx;
                end
            end
            PLAY: begin
                if (start_edge) begin
                    score_n   = 7'd0;
                    seen_n    = 1'b0;
                    restart_n = 1'b1;
                    cnt_n     = '0;
                    mole_n    = new_mole;
                    idx_n     = new_idx;
                end else begin
                    if (time_left != 5'd0) seen_n = 1'b1;
                    if (hit) begin
                        if (score_q != SMAX) score_n = score_q + 7'd1;
                        cnt_n  = '0;
                        mole_n = new_mole;
                        idx_n  = new_idx;
                    end else if (cnt_q == LAST) begin
                        cnt_n  = '0;
                        mole_n = new_mole;
                        idx_n  = new_idx;
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
`ifdef MOLE_MISS_PENALTY_EN
                    if (btn_edge != 4'b0 && !hit && score_q != 7'd0)
                        score_n = score_q - 7'd1;
`endif
                    // A zero seen before any nonzero value is timer reload lag, not game end.
                    if (time_left == 5'd0 && seen_q) begin
                        state_n = OVER;
                        mole_n  = 4'b0;
                        cnt_n   = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign timer_rst = (state_q != PLAY) | restart_q;
    assign game_over = (state_q == OVER);
    assign mole      = mole_q;
    assign score     = score_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// tb/tb_mole_game_ctrl.sv - self-checking bench for mole_game_ctrl with MOLE_PERIOD=8.
module tb_mole_game_ctrl;

`ifdef MOLE_MISS_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn = 4'b0;
    logic [4:0] time_left = 5'd20;
    logic       timer_rst;
    logic [3:0] mole;
    logic [6:0] score;
    logic       game_over;

    int n_chk = 0;
    int n_fail = 0;
    int sc_m = 0;

    mole_game_ctrl #(.MOLE_PERIOD(8), .SCORE_MAX(99)) dut (
        .clk(clk), .reset(reset), .start(start), .btn(btn), .time_left(time_left),
        .timer_rst(timer_rst), .mole(mole), .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [3:0] b;
        logic [4:0] tl;
        int         cyc;
        logic       e_trst;
        logic       e_go;
        logic [6:0] e_sc;
        logic       e_lit;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_move();
        logic [3:0] p;
        bit got;
        p = mole;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (mole != p) got = 1'b1;
        end
        chk("mole_move_timeout", int'(got), 1);
    endtask

    task automatic hit(input bit check_it);
        logic [3:0] p;
        wait_move();
        p = mole;
        btn = p;
        repeat (2) @(negedge clk);
        btn = 4'b0;
        repeat (2) @(negedge clk);
        if (sc_m < 99) sc_m++;
        if (check_it) begin
            chk("hit_score", int'(score), sc_m);
            chk("hit_onehot", $countones(mole), 1);
            chk("hit_moved", int'(mole != p), 1);
        end
    endtask

    task automatic miss(input bit wrong_single);
        logic [3:0] p;
        wait_move();
        p = mole;
        btn = wrong_single ? {p[2:0], p[3]} : 4'b1111;
        repeat (2) @(negedge clk);
        btn = 4'b0;
        repeat (2) @(negedge clk);
        if (PEN && sc_m > 0) sc_m--;
        chk("miss_score", int'(score), sc_m);
        chk("miss_no_move", int'(mole), int'(p));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_trst"}, int'(timer_rst), 1);
        chk({tag, "_mole"}, int'(mole), 0);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_go"}, int'(game_over), 0);
    endtask

    initial begin
        int pulses;
        //        st    btn      tl     cyc trst go  sc   lit
        vt[0] = '{1'b0, 4'b0001, 5'd20, 4, 1'b1, 1'b0, 7'd0, 1'b0};
        vt[1] = '{1'b0, 4'b1111, 5'd20, 4, 1'b1, 1'b0, 7'd0, 1'b0};
        vt[2] = '{1'b0, 4'b0000, 5'd20, 4, 1'b1, 1'b0, 7'd0, 1'b0};
        vt[3] = '{1'b1, 4'b0000, 5'd20, 4, 1'b0, 1'b0, 7'd0, 1'b1};
        vt[4] = '{1'b0, 4'b0000, 5'd20, 4, 1'b0, 1'b0, 7'd0, 1'b1};
        vt[5] = '{1'b0, 4'b0000, 5'd0,  3, 1'b1, 1'b1, 7'd0, 1'b0};
        vt[6] = '{1'b0, 4'b0100, 5'd0,  4, 1'b1, 1'b1, 7'd0, 1'b0};
        vt[7] = '{1'b1, 4'b0000, 5'd20, 4, 1'b0, 1'b0, 7'd0, 1'b1};
        vt[8] = '{1'b0, 4'b0000, 5'd20, 4, 1'b0, 1'b0, 7'd0, 1'b1};

        repeat (3) @(negedge clk);
        chk_reset_outs("por");
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            start = vt[i].st;
            btn = vt[i].b;
            time_left = vt[i].tl;
            repeat (vt[i].cyc) @(negedge clk);
            chk($sformatf("vec%0d_trst", i), int'(timer_rst), int'(vt[i].e_trst));
            chk($sformatf("vec%0d_go", i), int'(game_over), int'(vt[i].e_go));
            chk($sformatf("vec%0d_score", i), int'(score), int'(vt[i].e_sc));
            if (vt[i].e_lit) chk($sformatf("vec%0d_mole_onehot", i), $countones(mole), 1);
            else             chk($sformatf("vec%0d_mole_off", i), int'(mole), 0);
        end

        sc_m = 0;
        for (int i = 0; i < 5; i++) hit(1'b1);

        wait_move();
        for (int i = 0; i < 4; i++) begin
            logic [3:0] p;
            p = mole;
            repeat (7) @(negedge clk);
            chk("period_hold", int'(mole), int'(p));
            @(negedge clk);
            chk("period_moved", int'(mole != p), 1);
            chk("period_onehot", $countones(mole), 1);
        end

        pulses = 0;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (timer_rst) pulses++;
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        sc_m = 0;
        chk("restart_trst_pulse", pulses, 1);
        chk("restart_score", int'(score), 0);
        chk("restart_go", int'(game_over), 0);
        chk("restart_onehot", $countones(mole), 1);

        for (int i = 0; i < 3; i++) hit(1'b0);
        chk("score_before_miss", int'(score), 3);
        miss(1'b0);
        miss(1'b1);
        pulse_start();
        sc_m = 0;
        miss(1'b0);

        time_left = 5'd0;
        repeat (2) @(negedge clk);
        chk("over_go", int'(game_over), 1);
        chk("over_mole", int'(mole), 0);
        pulse_start();
        sc_m = 0;
        repeat (10) @(negedge clk);
        chk("lag_go", int'(game_over), 0);
        chk("lag_trst", int'(timer_rst), 0);
        hit(1'b1);
        time_left = 5'd20;
        repeat (2) @(negedge clk);
        chk("lag_nonzero_go", int'(game_over), 0);
        time_left = 5'd0;
        repeat (2) @(negedge clk);
        chk("end_go", int'(game_over), 1);
        chk("end_mole", int'(mole), 0);
        chk("end_score", int'(score), 1);
        btn = 4'b0010;
        repeat (2) @(negedge clk);
        btn = 4'b0;
        repeat (4) @(negedge clk);
        chk("over_btn_score", int'(score), 1);
        chk("over_btn_go", int'(game_over), 1);

        time_left = 5'd20;
        pulse_start();
        sc_m = 0;
        for (int i = 0; i < 100; i++) hit(1'b0);
        chk("sat_score", int'(score), 99);
        chk("sat_onehot", $countones(mole), 1);

        reset = 1'b0;
        #1;
        chk_reset_outs("midgame");
        @(negedge clk);
        reset = 1'b1;
        btn = 4'b0001;
        repeat (2) @(negedge clk);
        btn = 4'b0;
        repeat (6) @(negedge clk);
        chk_reset_outs("after_release");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
